dbl_reg_reader: RTL
===================

Name: dbl_reg_reader

Overview:
- Serial-to-parallel reader for the 58-bit double-length recirculating registers (ID, MQ, PN) written by the product gates.
- On request, waits for the start of the next even word, shifts in one full 58-bit revolution of the selected track output (PI, PR or PP), then presents a parallel snapshot to the console/host side with a valid/ack handshake.
- Read-only observer; never drives the track inputs.

Parameters:
- WORD_BITS, 29, bit times per word.
- DBL_BITS, 58, bits per double-length register (2 x WORD_BITS).

Ports:
- CLOCK  in  1  system clock; one bit time per cycle.
- rst  in  1  reset, asynchronous, active-high.
- T0  in  1  first bit time of every word.
- CE  in  1  high during even words; sampled with T0.
- sel  in  2  track select, sampled at request: 0=ID(PI), 1=MQ(PR), 2=PN(PP), 3=reserved.
- PI  in  1  ID track serial output.
- PR  in  1  MQ track serial output.
- PP  in  1  PN track serial output.
- req  in  1  capture request pulse.
- ack  in  1  consumer has taken data.
- busy  out  1  request accepted, capture not yet complete.
- valid  out  1  data holds a complete snapshot.
- data  out  58  snapshot; bit 0 = first bit received.
- frame_err  out  1  sticky framing error; cleared by next accepted req.

Behaviour:
- Reset (async): state IDLE, busy=0, valid=0, data=0, frame_err=0, bit counter=0, latched sel=0.
- States: IDLE, ARMED, CAPTURE, HOLD.
- IDLE: req=1 latches sel, clears frame_err, goes to ARMED. busy=1 from the next cycle.
- req with sel=3: ignored; remain IDLE.
- ARMED: on a cycle with T0=1 & CE=1, shift the selected bit into position 0, set counter=1, go to CAPTURE. T0 with CE=0 is ignored.
- CAPTURE: each cycle shift the selected bit into position counter, then increment counter.
  - When counter reaches DBL_BITS-1, the last bit is written, state goes to HOLD, busy=0, valid=1.
  - Latency from qualifying T0 to valid=1 is exactly 58 cycles.
- Framing check, CAPTURE only:
  - T0 must be 1 exactly when counter=WORD_BITS (29), with CE=0.
  - T0=1 at any other counter value, or T0 missing at 29, sets frame_err=1 and returns to ARMED. The counter resets.
  - A T0 & CE in that same cycle restarts the capture immediately (counter=1).
- data updates only during CAPTURE. Partially shifted contents are visible but undefined until valid=1. data is stable throughout HOLD.
- HOLD: valid stays 1 until ack=1.
  - ack alone: go to IDLE, valid=0 next cycle.
  - ack and req in the same cycle: valid=0, latch new sel, go directly to ARMED.
- req in ARMED, CAPTURE or HOLD without ack: ignored. No queueing, no sel change.
- ack outside HOLD: ignored.
- Reset mid-capture: immediate return to reset values; no partial valid.
- Counter is 6 bits and never exceeds 57.

Decomposition:
- Shared package g15_pkg holds:
  - constants WORD_BITS=29 and DBL_BITS=58
  - enum typedef for the reader state
  - 2-bit enum typedef for track select (TRK_ID, TRK_MQ, TRK_PN)
- One sub-module, ser_capture: indexed serial-to-parallel shift register with a bit counter and load enable. This keeps the FSM and handshake logic separate from the datapath.

Test Plan:
- Reset mid-CAPTURE (assert rst at counter=20) -> busy=0, valid=0, data=0 in the same cycle; no valid after rst release.
- sel=2, req, PP stream 0x2AAAAAAAAAAAAAA (bit0 first), T0 every 29 cycles, CE alternating -> valid exactly 58 cycles after the even-word T0; data=0x2AAAAAAAAAAAAAA; busy low with valid high.
- req while CE=0 at next T0 -> no capture begins until the following even T0; latency measured from that T0 is still 58.
- Extra T0 injected at counter=10 -> frame_err=1, state ARMED; next even T0 captures a correct word; frame_err stays 1 until next req.
- HOLD with ack=1 and req=1 (sel=0) in the same cycle -> valid=0 next cycle, busy=1; next capture returns the PI pattern 0x155555555555555.
- req with sel=3, and req during CAPTURE -> no state change, busy/valid unchanged, no data corruption.

Source files
------------

// File: rtl/g15_pkg.sv
// rtl/g15_pkg.sv - shared constants and types for the double-length register reader
package g15_pkg;
   localparam int WORD_BITS = 29;
   localparam int DBL_BITS  = 2 * WORD_BITS;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } rd_state_t;

   typedef enum logic [1:0] {
      TRK_ID  = 2'd0,
      TRK_MQ  = 2'd1,
      TRK_PN  = 2'd2,
      TRK_RSV = 2'd3
   } trk_sel_t;
endpackage

// File: rtl/ser_capture.sv
// rtl/ser_capture.sv - indexed serial-to-parallel shift register with bit counter
module ser_capture
   import g15_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                shift,
   input  logic                clr,
   input  logic                din,
   output logic [DBL_BITS-1:0] data,
   output logic [CNT_W-1:0]    count,
   output logic                last
);
   assign last = (count == CNT_W'(DBL_BITS - 1));

   // Bits land at their own index, so the word assembles bit 0 first without shifting the whole register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         count <= '0;
      end else if (start) begin
         data[0] <= din;
         count   <= CNT_W'(1);
      end else if (shift) begin
         data[count] <= din;
         count       <= last ? '0 : count + CNT_W'(1);
      end else if (clr) begin
         count <= '0;
      end
   end
endmodule

// File: rtl/dbl_reg_reader.sv
// rtl/dbl_reg_reader.sv - captures one revolution of a double-length track into a parallel snapshot
module dbl_reg_reader
   import g15_pkg::*;
(
   input  logic                CLOCK,
   input  logic                rst,
   input  logic                T0,
   input  logic                CE,
   input  logic [1:0]          sel,
   input  logic                PI,
   input  logic                PR,
   input  logic                PP,
   input  logic                req,
   input  logic                ack,
   output logic                busy,
   output logic                valid,
   output logic [DBL_BITS-1:0] data,
   output logic                frame_err
);
   rd_state_t         state, state_n;
   trk_sel_t          sel_q, sel_n;
   logic              ferr_n;
   logic              start, shift, clr, din, last, frame_ok, req_ok;
   logic [CNT_W-1:0]  count;

   assign busy   = (state == ST_ARMED) || (state == ST_CAPTURE);
   assign valid  = (state == ST_HOLD);
   assign req_ok = req && (trk_sel_t'(sel) != TRK_RSV);

   always_comb begin
      din = 1'b0;
      case (sel_q)
         TRK_ID:  din = PI;
         TRK_MQ:  din = PR;
         TRK_PN:  din = PP;
         default: din = 1'b0;
      endcase
   end

   // The only legal T0 inside a capture is the odd-word boundary halfway through.
   assign frame_ok = (count == CNT_W'(WORD_BITS)) ? (T0 && !CE) : !T0;

   always_comb begin
      state_n = state;
      sel_n   = sel_q;
      ferr_n  = frame_err;
      start   = 1'b0;
      shift   = 1'b0;
      clr     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_ok) begin
               sel_n   = trk_sel_t'(sel);
               ferr_n  = 1'b0;
               state_n = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (T0 && CE) begin
               start   = 1'b1;
               state_n = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (!frame_ok) begin
               ferr_n = 1'b1;
               if (T0 && CE) begin
                  start = 1'b1;
               end else begin
                  clr     = 1'b1;
                  state_n = ST_ARMED;
               end
            end else begin
               shift = 1'b1;
               if (last) state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ack) begin
               if (req_ok) begin
                  sel_n   = trk_sel_t'(sel);
                  ferr_n  = 1'b0;
                  state_n = ST_ARMED;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel_q     <= TRK_ID;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         sel_q     <= sel_n;
         frame_err <= ferr_n;
      end
   end

   ser_capture u_cap (
      .clk   (CLOCK),
      .rst   (rst),
      .start (start),
      .shift (shift),
      .clr   (clr),
      .din   (din),
      .data  (data),
      .count (count),
      .last  (last)
   );
endmodule
